// File: rtl/uart_core_param.sv
// rtl/uart_core_param.sv - parametrised full-duplex UART core with 16x oversampled receiver
// TX frames are timed from acceptance; RX decisions are made only on the shared 16x tick.
module uart_core_param #(
    parameter int DATA_LENGTH = 8,
    parameter int PARITY_EN   = 1,
    parameter int STOP_BITS   = 1,
    parameter int CLK_DIV     = 54
) (
    input  logic                   clk1,
    input  logic                   rst,
    input  logic                   parity_type,
    input  logic                   loopback,
    input  logic [DATA_LENGTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic                   tx_serialout,
    output logic                   tx_done,
    input  logic                   rx_serialin,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   rx_done,
    output logic                   parity_error,
    output logic                   framing_error
);

    localparam int BIT_CYC = 16 * CLK_DIV;
    localparam int PCNT_W  = $clog2(BIT_CYC);
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W   = $clog2(DATA_LENGTH);

    // ---------------- 16x tick generator ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             tick16;

    assign tick16 = (div_cnt == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
        end else if (tick16) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // ---------------- transmitter ----------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t              tx_state, tx_state_nxt;
    logic [PCNT_W-1:0]      tx_pcnt;
    logic [IDX_W-1:0]       tx_idx;
    logic                   tx_stop_idx;
    logic [DATA_LENGTH-1:0] tx_shreg;
    logic                   tx_par;
    logic                   tx_bit_end;
    logic                   tx_last_data;
    logic                   tx_last_stop;

    assign tx_bit_end   = (tx_pcnt == PCNT_W'(BIT_CYC - 1));
    assign tx_last_data = (tx_idx == IDX_W'(DATA_LENGTH - 1));
    assign tx_last_stop = (tx_stop_idx == 1'(STOP_BITS - 1));

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            tx_state <= TX_IDLE;
        end else begin
            tx_state <= tx_state_nxt;
        end
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_ready     = 1'b0;
        tx_done      = 1'b0;
        tx_serialout = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) tx_state_nxt = TX_START;
            end
            TX_START: begin
                tx_serialout = 1'b0;
                if (tx_bit_end) tx_state_nxt = TX_DATA;
            end
            TX_DATA: begin
                tx_serialout = tx_shreg[0];
                if (tx_bit_end && tx_last_data)
                    tx_state_nxt = (PARITY_EN != 0) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                tx_serialout = tx_par;
                if (tx_bit_end) tx_state_nxt = TX_STOP;
            end
            TX_STOP: begin
                if (tx_bit_end && tx_last_stop) begin
                    tx_done      = 1'b1;
                    tx_state_nxt = TX_IDLE;
                end
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    // Parity is resolved at acceptance: odd parity is the inverted XOR reduction.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            tx_pcnt     <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            tx_shreg    <= '0;
            tx_par      <= 1'b0;
        end else if (tx_state == TX_IDLE) begin
            tx_pcnt     <= '0;
            tx_idx      <= '0;
            tx_stop_idx <= 1'b0;
            if (tx_valid) begin
                tx_shreg <= tx_data;
                tx_par   <= (^tx_data) ^ parity_type;
            end
        end else begin
            tx_pcnt <= tx_bit_end ? '0 : tx_pcnt + 1'b1;
            if (tx_bit_end) begin
                if (tx_state == TX_DATA) begin
                    tx_shreg <= tx_shreg >> 1;
                    tx_idx   <= tx_idx + 1'b1;
                end
                if (tx_state == TX_STOP) tx_stop_idx <= tx_stop_idx + 1'b1;
            end
        end
    end

    // ---------------- receiver ----------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK
    } rx_state_t;

    rx_state_t              rx_state, rx_state_nxt;
    logic                   rx_sync1, rx_sync2;
    logic                   rx_line;
    logic [3:0]             rx_tcnt;
    logic [IDX_W-1:0]       rx_idx;
    logic [DATA_LENGTH-1:0] rx_shreg;
    logic                   rx_par_type;
    logic                   rx_par_bit;
    logic                   rx_sample;
    logic                   rx_last_data;

    assign rx_line      = rx_sync2;
    assign rx_last_data = (rx_idx == IDX_W'(DATA_LENGTH - 1));

    // Start is checked at mid-bit (8 ticks), then every bit 16 ticks later.
    always_comb begin
        rx_sample = 1'b0;
        if (tick16) begin
            if (rx_state == RX_START)
                rx_sample = (rx_tcnt == 4'd7);
            else if (rx_state == RX_DATA || rx_state == RX_PARITY || rx_state == RX_STOP)
                rx_sample = (rx_tcnt == 4'd15);
        end
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_state <= RX_IDLE;
        end else begin
            rx_sync1 <= loopback ? tx_serialout : rx_serialin;
            rx_sync2 <= rx_sync1;
            rx_state <= rx_state_nxt;
        end
    end

    always_comb begin
        rx_state_nxt = rx_state;
        case (rx_state)
            RX_IDLE:   if (tick16 && !rx_line) rx_state_nxt = RX_START;
            RX_START:  if (rx_sample) rx_state_nxt = rx_line ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_sample && rx_last_data)
                           rx_state_nxt = (PARITY_EN != 0) ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_sample) rx_state_nxt = RX_STOP;
            RX_STOP:   if (rx_sample) rx_state_nxt = rx_line ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (tick16 && rx_line) rx_state_nxt = RX_IDLE;
            default:   rx_state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            rx_tcnt       <= '0;
            rx_idx        <= '0;
            rx_shreg      <= '0;
            rx_par_type   <= 1'b0;
            rx_par_bit    <= 1'b0;
            rx_done       <= 1'b0;
            data_out      <= '0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            if (rx_state == RX_IDLE) begin
                rx_tcnt <= '0;
                rx_idx  <= '0;
                if (tick16 && !rx_line) rx_par_type <= parity_type;
            end else if (tick16) begin
                rx_tcnt <= rx_sample ? 4'd0 : rx_tcnt + 4'd1;
            end
            if (rx_sample) begin
                case (rx_state)
                    RX_DATA: begin
                        rx_shreg <= {rx_line, rx_shreg[DATA_LENGTH-1:1]};
                        rx_idx   <= rx_idx + 1'b1;
                    end
                    RX_PARITY: rx_par_bit <= rx_line;
                    RX_STOP: begin
                        rx_done       <= 1'b1;
                        data_out      <= rx_shreg;
                        parity_error  <= (PARITY_EN != 0) &&
                                         (rx_par_bit != ((^rx_shreg) ^ rx_par_type));
                        framing_error <= !rx_line;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_core_param.sv
// tb/tb_uart_core_param.sv - scoreboard bench for uart_core_param (8 data, parity, 1 stop, CLK_DIV=4)
module tb_uart_core_param;

    localparam int BIT   = 64;
    localparam int FRAME = 704;

    logic       clk1 = 1'b0;
    logic       rst = 1'b0;
    logic       parity_type = 1'b0;
    logic       loopback = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       rx_serialin = 1'b1;
    logic       tx_ready, tx_serialout, tx_done;
    logic [7:0] data_out;
    logic       rx_done, parity_error, framing_error;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [9:0] sb[$];
    logic [9:0] exp_e;

    uart_core_param #(
        .DATA_LENGTH(8),
        .PARITY_EN(1),
        .STOP_BITS(1),
        .CLK_DIV(4)
    ) dut (
        .clk1(clk1),
        .rst(rst),
        .parity_type(parity_type),
        .loopback(loopback),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_serialout(tx_serialout),
        .tx_done(tx_done),
        .rx_serialin(rx_serialin),
        .data_out(data_out),
        .rx_done(rx_done),
        .parity_error(parity_error),
        .framing_error(framing_error)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk1) begin
        if (rst && rx_done) begin
            if (sb.size() == 0) begin
                check("rx_spurious", {31'b0, rx_done}, 32'd0);
            end else begin
                exp_e = sb.pop_front();
                check("rx_data", {24'b0, data_out}, {24'b0, exp_e[9:2]});
                check("rx_perr", {31'b0, parity_error}, {31'b0, exp_e[1]});
                check("rx_ferr", {31'b0, framing_error}, {31'b0, exp_e[0]});
            end
        end
    end

    task automatic wait_sb(input string tag);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk1);
        check(tag, sb.size(), 0);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 2000 && !tx_ready; i++) @(negedge clk1);
        check("tx_ready_wait", {31'b0, tx_ready}, 32'd1);
    endtask

    task automatic send_tx(input logic [7:0] d);
        logic [10:0] f;
        int n;
        f = {1'b1, (^d) ^ parity_type, d, 1'b0};
        @(negedge clk1);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_ready();
        sb.push_back({d, 2'b00});
        @(posedge clk1);
        n = 0;
        do begin
            @(negedge clk1);
            n++;
            if (n == 1) tx_valid = 1'b0;
            if (n % BIT == BIT / 2 && n / BIT < 11)
                check($sformatf("tx_bit%0d", n / BIT), {31'b0, tx_serialout}, {31'b0, f[n / BIT]});
        end while (!tx_done && n < 1000);
        check("tx_done_lat", n, FRAME);
    endtask

    task automatic drive_rx(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx_serialin = f[i];
            repeat (BIT) @(negedge clk1);
        end
        rx_serialin = 1'b1;
    endtask

    initial begin
        logic [7:0] seq [8];
        int last_cyc;
        logic p;
        seq = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF};

        repeat (3) @(negedge clk1);
        check("rst_txout", {31'b0, tx_serialout}, 32'd1);
        check("rst_txready", {31'b0, tx_ready}, 32'd1);
        check("rst_txdone", {31'b0, tx_done}, 32'd0);
        check("rst_dataout", {24'b0, data_out}, 32'd0);
        check("rst_rxdone", {31'b0, rx_done}, 32'd0);
        check("rst_perr", {31'b0, parity_error}, 32'd0);
        check("rst_ferr", {31'b0, framing_error}, 32'd0);
        rst = 1'b1;
        repeat (4) @(negedge clk1);

        // 1: single loopback frame with waveform and latency checks
        loopback = 1'b1;
        parity_type = 1'b0;
        send_tx(8'hA5);
        wait_sb("t1_rx_drain");

        // 2: back-to-back frames with tx_valid held
        last_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            wait_ready();
            if (k > 0) check("t2_spacing", cyc - last_cyc, FRAME + 1);
            last_cyc = cyc;
            tx_data  = seq[k];
            tx_valid = 1'b1;
            sb.push_back({seq[k], 2'b00});
            @(negedge clk1);
        end
        tx_valid = 1'b0;
        wait_sb("t2_rx_drain");

        // 3: external line, odd parity, wrong parity then correct
        loopback = 1'b0;
        parity_type = 1'b1;
        repeat (BIT) @(negedge clk1);
        sb.push_back({8'h0F, 2'b10});
        drive_rx(8'h0F, 1'b0, 1'b1);
        wait_sb("t3_perr_drain");
        p = (^8'h12) ^ 1'b1;
        sb.push_back({8'h12, 2'b00});
        drive_rx(8'h12, p, 1'b1);
        wait_sb("t3_ok_drain");

        // 4: framing error followed by a held-low line
        p = (^8'h55) ^ 1'b1;
        sb.push_back({8'h55, 2'b01});
        drive_rx(8'h55, p, 1'b0);
        rx_serialin = 1'b0;
        repeat (3 * BIT) @(negedge clk1);
        check("t4_ferr_seen", sb.size(), 0);
        check("t4_ferr_held", {31'b0, framing_error}, 32'd1);
        rx_serialin = 1'b1;
        repeat (BIT) @(negedge clk1);
        p = (^8'h3C) ^ 1'b1;
        sb.push_back({8'h3C, 2'b00});
        drive_rx(8'h3C, p, 1'b1);
        wait_sb("t4_ok_drain");

        // 5: short glitch is rejected as a false start
        rx_serialin = 1'b0;
        repeat (20) @(negedge clk1);
        rx_serialin = 1'b1;
        repeat (2 * BIT) @(negedge clk1);
        p = (^8'h81) ^ 1'b1;
        sb.push_back({8'h81, 2'b00});
        drive_rx(8'h81, p, 1'b1);
        wait_sb("t5_rx_drain");

        // 6: asynchronous reset in the middle of a loopback frame
        loopback = 1'b1;
        parity_type = 1'b0;
        repeat (BIT) @(negedge clk1);
        tx_data  = 8'h33;
        tx_valid = 1'b1;
        wait_ready();
        @(negedge clk1);
        tx_valid = 1'b0;
        repeat (200) @(negedge clk1);
        #2 rst = 1'b0;
        #1;
        check("t6_rst_txout", {31'b0, tx_serialout}, 32'd1);
        check("t6_rst_txready", {31'b0, tx_ready}, 32'd1);
        check("t6_rst_txdone", {31'b0, tx_done}, 32'd0);
        check("t6_rst_rxdone", {31'b0, rx_done}, 32'd0);
        repeat (3) @(negedge clk1);
        check("t6_rst_dataout", {24'b0, data_out}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk1);
        send_tx(8'h5A);
        wait_sb("t6_rx_drain");

        repeat (BIT) @(negedge clk1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
